wb_writer: RTL and testbench

WB_WRITER -- requirements
Module: wb_writer

---
 rtl/wb_writer.sv | 166 ++++++++++++++++
 tb/tb_wb_writer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_writer.sv
// wb_writer: writeback stage driving the register-file write port (A3/WE3/WD3).
// ALU and PC+4 results are written one cycle after acceptance; loads park in
// WAIT_LOAD until the memory returns data. rd=0 and reserved sources retire
// without writing. retire_count tracks every retired instruction.
// Optional build macro WB_WRITER_FWD_EN adds fwd_valid/fwd_rd/fwd_data outputs
// that mirror the write port for decode-stage bypass.
module wb_writer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  reg_write_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic [1:0]            result_src_i,
  input  logic [DATA_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  flush_i,
  output logic [ADDR_WIDTH-1:0] A3,
  output logic                  WE3,
  output logic [DATA_WIDTH-1:0] WD3,
`ifdef WB_WRITER_FWD_EN
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
`endif
  output logic [31:0]           retire_count
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   rd_reg, rd_next;     // destination of the pending load
  logic                    rw_reg, rw_next;     // write enable of the pending load
  logic                    we_reg, we_next;
  logic [ADDR_WIDTH-1:0]   a3_reg, a3_next;
  logic [DATA_WIDTH-1:0]   wd_reg, wd_next;
  logic [31:0]             count_reg, count_next;

  // An instruction retiring this cycle, and what it would write.
  logic                    commit;
  logic                    commit_we;
  logic [ADDR_WIDTH-1:0]   commit_rd;
  logic [DATA_WIDTH-1:0]   commit_data;
  logic                    accept;

  // Next-state, handshake and retirement decode.
  always_comb begin
    state_next  = state_reg;
    rd_next     = rd_reg;
    rw_next     = rw_reg;
    we_next     = 1'b0;
    a3_next     = a3_reg;
    wd_next     = wd_reg;
    count_next  = count_reg;
    commit      = 1'b0;
    commit_we   = 1'b0;
    commit_rd   = rd_i;
    commit_data = alu_result_i;
    ready_o     = (state_reg == IDLE) && !flush_i;
    accept      = valid_i && ready_o;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (result_src_i)
            SRC_LOAD: begin
              state_next = WAIT_LOAD;
              rd_next    = rd_i;
              rw_next    = reg_write_i;
            end
            SRC_ALU: begin
              commit      = 1'b1;
              commit_we   = reg_write_i;
              commit_data = alu_result_i;
            end
            SRC_PC4: begin
              commit      = 1'b1;
              commit_we   = reg_write_i;
              commit_data = pc_plus4_i;
            end
            default: begin
              // Reserved source: retires but never writes.
              commit    = 1'b1;
              commit_we = 1'b0;
            end
          endcase
        end
      end
      WAIT_LOAD: begin
        // Flush wins over load data arriving in the same cycle.
        if (flush_i) begin
          state_next = IDLE;
        end else if (mem_rvalid_i) begin
          state_next  = IDLE;
          commit      = 1'b1;
          commit_we   = rw_reg;
          commit_rd   = rd_reg;
          commit_data = mem_rdata_i;
        end
      end
      default: state_next = IDLE;
    endcase

    if (commit) begin
      count_next = count_reg + 32'd1;
      // x0 is hardwired; A3/WD3 only move when a real write happens.
      if (commit_we && (commit_rd != '0)) begin
        we_next = 1'b1;
        a3_next = commit_rd;
        wd_next = commit_data;
      end
    end
  end

  // FSM state and captured load destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rd_reg    <= '0;
      rw_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      rd_reg    <= rd_next;
      rw_reg    <= rw_next;
    end
  end

  // Registered write port and retirement counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_reg    <= 1'b0;
      a3_reg    <= '0;
      wd_reg    <= '0;
      count_reg <= '0;
    end else begin
      we_reg    <= we_next;
      a3_reg    <= a3_next;
      wd_reg    <= wd_next;
      count_reg <= count_next;
    end
  end

  assign WE3          = we_reg;
  assign A3           = a3_reg;
  assign WD3          = wd_reg;
  assign retire_count = count_reg;

`ifdef WB_WRITER_FWD_EN
  assign fwd_valid = we_reg;
  assign fwd_rd    = a3_reg;
  assign fwd_data  = wd_reg;
`endif

endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed scenarios plus randomized traffic for wb_writer,
// checked cycle by cycle against a transaction-level reference model.
module tb_wb_writer;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          valid_i, ready_o, reg_write_i, mem_rvalid_i, flush_i;
  logic [AW-1:0] rd_i, A3;
  logic [1:0]    result_src_i;
  logic [DW-1:0] alu_result_i, pc_plus4_i, mem_rdata_i, WD3;
  logic          WE3;
  logic [31:0]   retire_count;
`ifdef WB_WRITER_FWD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: the pending load (if any) and the expected port values.
  bit            m_busy;
  logic [AW-1:0] m_rd;
  bit            m_rw;
  bit            m_we;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd;
  logic [31:0]   m_count;

  wb_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .reg_write_i  (reg_write_i),
    .rd_i         (rd_i),
    .result_src_i (result_src_i),
    .alu_result_i (alu_result_i),
    .pc_plus4_i   (pc_plus4_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .flush_i      (flush_i),
    .A3           (A3),
    .WE3          (WE3),
    .WD3          (WD3),
`ifdef WB_WRITER_FWD_EN
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
`endif
    .retire_count (retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_rd = '0; m_rw = 0;
    m_we = 0; m_a3 = '0; m_wd = '0; m_count = '0;
  endtask

  // One instruction leaves the stage; it writes only a nonzero rd it is allowed to.
  task automatic model_retire(input logic [AW-1:0] rd, input bit rw, input logic [DW-1:0] data);
    m_count = m_count + 32'd1;
    if (rw && rd != '0) begin
      m_we = 1; m_a3 = rd; m_wd = data;
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, ".WE3"}, 64'(WE3), 64'(m_we));
    check({tag, ".A3"},  64'(A3),  64'(m_a3));
    check({tag, ".WD3"}, 64'(WD3), 64'(m_wd));
    check({tag, ".cnt"}, 64'(retire_count), 64'(m_count));
`ifdef WB_WRITER_FWD_EN
    check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(m_we));
    check({tag, ".fwd_rd"},    64'(fwd_rd),    64'(m_a3));
    check({tag, ".fwd_data"},  64'(fwd_data),  64'(m_wd));
`endif
  endtask

  // Drive one cycle of inputs (called at posedge+1), check ready, advance the
  // model, then check the registered outputs just after the clock edge.
  task automatic cycle(input string tag, input bit v, input bit rw, input logic [AW-1:0] rd,
                       input logic [1:0] src, input logic [DW-1:0] alu, input logic [DW-1:0] pc4,
                       input bit rv, input logic [DW-1:0] rdata, input bit fl);
    valid_i = v; reg_write_i = rw; rd_i = rd; result_src_i = src;
    alu_result_i = alu; pc_plus4_i = pc4; mem_rvalid_i = rv; mem_rdata_i = rdata; flush_i = fl;
    #1;
    check({tag, ".ready"}, 64'(ready_o), 64'(!m_busy && !fl));
    m_we = 0;
    if (m_busy) begin
      if (fl) m_busy = 0;
      else if (rv) begin
        model_retire(m_rd, m_rw, rdata);
        m_busy = 0;
      end
    end else if (v && !fl) begin
      case (src)
        2'd0: model_retire(rd, rw, alu);
        2'd1: begin m_busy = 1; m_rd = rd; m_rw = rw; end
        2'd2: model_retire(rd, rw, pc4);
        default: model_retire(rd, 1'b0, alu);
      endcase
    end
    @(posedge clk);
    #1;
    check_ports(tag);
  endtask

  task automatic idle_inputs();
    valid_i = 0; reg_write_i = 0; rd_i = '0; result_src_i = 2'd0;
    alu_result_i = '0; pc_plus4_i = '0; mem_rvalid_i = 0; mem_rdata_i = '0; flush_i = 0;
  endtask

  // Asynchronous reset pulse taken mid-cycle; effect must be immediate.
  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    #1;
    model_reset();
    check_ports({tag, ".rst"});
    @(negedge clk);
    rst = 1'b0;
    #1;
    check({tag, ".ready_after_rst"}, 64'(ready_o), 64'(1));
    @(posedge clk);
    #1;
    check_ports({tag, ".post_rst"});
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1;
    do_reset("init");

    // ALU write: rd=10, 0x2A.
    cycle("alu", 1, 1, 5'd10, 2'd0, 32'h0000_002A, 32'h0, 0, 32'h0, 0);
    check("alu.cnt_is_1", 64'(retire_count), 64'(1));
    cycle("alu_hold", 0, 0, 5'd0, 2'd0, 32'h1111, 32'h2222, 0, 32'h0, 0);

    // Load rd=3, data after 3 wait cycles (upstream keeps offering meanwhile).
    cycle("ld_acc", 1, 1, 5'd3, 2'd1, 32'h0, 32'h0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++)
      cycle("ld_wait", 1, 1, 5'd9, 2'd0, 32'h5555, 32'h0, 0, 32'h0, 0);
    cycle("ld_data", 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF, 0);
    check("ld.WD3", 64'(WD3), 64'(32'hDEAD_BEEF));

    // rd=0 via PC+4: no write, count still advances.
    cycle("rd0", 1, 1, 5'd0, 2'd2, 32'h0, 32'h0000_1004, 0, 32'h0, 0);
    // Reserved source: no write, counted.
    cycle("src11", 1, 1, 5'd4, 2'd3, 32'h77, 32'h88, 0, 32'h0, 0);
    // Load then flush (same cycle as rvalid), then a late rvalid.
    cycle("fl_acc", 1, 1, 5'd7, 2'd1, 32'h0, 32'h0, 0, 32'h0, 0);
    cycle("fl_flush", 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 1, 32'hCAFE_F00D, 1);
    cycle("fl_late", 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 1, 32'hCAFE_F00D, 0);
    // Flush in IDLE blocks a same-cycle valid.
    cycle("fl_idle", 1, 1, 5'd12, 2'd0, 32'hABCD, 32'h0, 0, 32'h0, 1);

    // Reset while waiting on a load to rd=5.
    cycle("rst_ld", 1, 1, 5'd5, 2'd1, 32'h0, 32'h0, 0, 32'h0, 0);
    do_reset("mid_load");
    cycle("rst_late_rv", 0, 0, 5'd0, 2'd0, 32'h0, 32'h0, 1, 32'h1234_5678, 0);

    // Counter wrap with back-to-back ALU writes.
    force dut.count_reg = 32'hFFFF_FFFF;
    #1;
    release dut.count_reg;
    m_count = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++)
      cycle("stream", 1, 1, 5'(i + 1), 2'd0, 32'(100 + i), 32'h0, 0, 32'h0, 0);
    check("wrap.cnt_is_3", 64'(retire_count), 64'(3));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
      cycle("rand", $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, rd,
            2'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 4, $urandom,
            $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
